prog_ram_loader: RTL and testbench

Writer side of the program memory fetched by the ACC CPU core. It takes a byte stream from a byte source (UART receiver or test host) and assembles it into 16-bit words. The words are written sequentially into an internal 2^AW x DW RAM. Once loading is complete, the core reads the RAM through a registered read port that behaves like the existing ROM port: chip select, address, data_out.

---
 rtl/prog_ram_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_ram_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram_loader.sv
// Program RAM loader: assembles a length-prefixed big-endian byte stream into 16-bit words
// written from BASE_ADDR, then serves registered ROM-style reads. Optional: LOADER_CHECKSUM_EN.
module prog_ram_loader #(
   parameter int AW        = 11,
   parameter int DW        = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN_H = 3'd1,
      S_LEN_L = 3'd2,
      S_DAT_H = 3'd3,
      S_DAT_L = 3'd4,
      S_WRITE = 3'd5,
`ifdef LOADER_CHECKSUM_EN
      S_CHK   = 3'd6,
`endif
      S_FIN   = 3'd7
   } state_t;

   // Words available from BASE_ADDR to the top of the RAM; wider than len so 2^16 fits.
   localparam logic [16:0] W_CAP = 17'((2 ** AW) - BASE_ADDR);

   state_t          r_state, w_state_nx;
   logic [7:0]      r_len_h;
   logic [15:0]     r_rem;
   logic [AW-1:0]   r_wr_addr;
   logic [DW-1:0]   r_word;
   logic            r_fail;
   logic            r_done, r_err;
   logic [DW-1:0]   r_ram [0:(2**AW)-1];
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      r_csum;
`endif

   logic            w_acc;
   logic [15:0]     w_len;
   logic            w_ovf;

   assign w_acc = rx_valid && rx_ready;
   assign w_len = {r_len_h, rx_data};
   assign w_ovf = {1'b0, w_len} > W_CAP;
   assign busy  = (r_state != S_IDLE);
   assign done  = r_done;
   assign err   = r_err;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      rx_ready   = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_state_nx = S_LEN_H;
         S_LEN_H: begin
            rx_ready = 1'b1;
            if (w_acc) w_state_nx = S_LEN_L;
         end
         S_LEN_L: begin
            rx_ready = 1'b1;
            if (w_acc) w_state_nx = (w_len == 16'd0 || w_ovf) ? S_FIN : S_DAT_H;
         end
         S_DAT_H: begin
            rx_ready = 1'b1;
            if (w_acc) w_state_nx = S_DAT_L;
         end
         S_DAT_L: begin
            rx_ready = 1'b1;
            if (w_acc) w_state_nx = S_WRITE;
         end
`ifdef LOADER_CHECKSUM_EN
         S_WRITE: w_state_nx = (r_rem == 16'd1) ? S_CHK : S_DAT_H;
         S_CHK: begin
            rx_ready = 1'b1;
            if (w_acc) w_state_nx = S_FIN;
         end
`else
         S_WRITE: w_state_nx = (r_rem == 16'd1) ? S_FIN : S_DAT_H;
`endif
         S_FIN:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_h   <= '0;
         r_rem     <= '0;
         r_wr_addr <= '0;
         r_word    <= '0;
         r_fail    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         data_out  <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum    <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_done    <= 1'b0;
               r_err     <= 1'b0;
               r_fail    <= 1'b0;
               r_wr_addr <= AW'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
               r_csum    <= '0;
`endif
            end
            S_LEN_H: if (w_acc) r_len_h <= rx_data;
            S_LEN_L: if (w_acc) begin
               r_rem  <= w_len;
               r_fail <= w_ovf;
            end
            S_DAT_H: if (w_acc) begin
               r_word[15:8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
               r_csum       <= r_csum ^ rx_data;
`endif
            end
            S_DAT_L: if (w_acc) begin
               r_word[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
               r_csum      <= r_csum ^ rx_data;
`endif
            end
            S_WRITE: begin
               r_wr_addr <= r_wr_addr + 1'b1;
               r_rem     <= r_rem - 16'd1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (w_acc) r_fail <= (rx_data != r_csum);
`endif
            S_FIN: begin
               r_done <= !r_fail;
               r_err  <= r_fail;
            end
            default: ;
         endcase
         // Reads are only served while idle, so a load never races a read.
         if (cs && r_state == S_IDLE) data_out <= r_ram[addr];
      end
   end

   // Contents survive reset; the write is suppressed in a reset cycle so an abort never commits.
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_WRITE) r_ram[r_wr_addr] <= r_word;
   end

endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader; read data checked against a scoreboard of model RAM values.
module tb_prog_ram_loader;

   localparam int AW = 11;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready, busy, done, err;
   logic          cs = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] data_out;

   int            n_chk = 0;
   int            n_err = 0;
   logic [15:0]   model [0:(2**AW)-1];
   logic [15:0]   sb_q [$];
   logic [7:0]    tx_q [$];
   logic [15:0]   wq [$];

   prog_ram_loader #(.AW(AW), .DW(DW), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .busy(busy), .done(done), .err(err),
      .cs(cs), .addr(addr), .data_out(data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      check("rx_ready_wait", rx_ready, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic send_stream(input int gap, input int start_idx, input int nwords);
      for (int i = 0; i < tx_q.size(); i++) begin
         send_byte(tx_q[i]);
         if (gap > 0) rx_valid = 1'b0;
         if (i >= 3 && i[0] && i < 2 + 2 * nwords) begin
            @(negedge clk);
            check("ready_gap", rx_ready, 1'b0);
         end
         if (i == start_idx) pulse_start();
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic build_tx();
      logic [7:0] x = 8'h00;
      tx_q.delete();
      tx_q.push_back(8'(wq.size() >> 8));
      tx_q.push_back(8'(wq.size()));
      foreach (wq[i]) begin
         tx_q.push_back(wq[i][15:8]);
         tx_q.push_back(wq[i][7:0]);
         x = x ^ wq[i][15:8] ^ wq[i][7:0];
      end
`ifdef LOADER_CHECKSUM_EN
      if (wq.size() > 0) tx_q.push_back(x);
`endif
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 200) begin
         t++;
         @(negedge clk);
      end
      check("idle_wait", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic load_ok(input int gap, input int start_idx);
      build_tx();
      pulse_start();
      send_stream(gap, start_idx, wq.size());
      wait_idle();
      check("load_done", done, 1'b1);
      check("load_err", err, 1'b0);
      foreach (wq[i]) model[i] = wq[i];
   endtask

   task automatic rd(input int a);
      logic [15:0] e;
      sb_q.push_back(model[a]);
      cs   = 1'b1;
      addr = AW'(a);
      @(posedge clk); #1;
      cs = 1'b0;
      e  = sb_q.pop_front();
      check("read_data", data_out, e);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ready", rx_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_dout", data_out, 16'h0000);

      wq = '{16'h1234, 16'hABCD};
      load_ok(0, -1);
      rd(0);
      rd(1);
      addr = '0;
      @(posedge clk); #1;
      check("dout_hold_cs0", data_out, 16'hABCD);

      tx_q = '{8'h00, 8'h00};
      pulse_start();
      check("start_clears_done", done, 1'b0);
      send_stream(0, -1, 0);
      check("len0_fin_busy", busy, 1'b1);
      @(posedge clk); #1;
      check("len0_done", done, 1'b1);
      check("len0_busy", busy, 1'b0);
      rd(0);

      tx_q = '{8'h08, 8'h01};
      pulse_start();
      send_stream(0, -1, 0);
      @(posedge clk); #1;
      check("ovf_err", err, 1'b1);
      check("ovf_done", done, 1'b0);
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      @(negedge clk);
      check("ovf_no_ready", rx_ready, 1'b0);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      check("ovf_idle", busy, 1'b0);
      rd(1);

      wq = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789};
      load_ok(4, 4);
      for (int i = 0; i < 4; i++) rd(i);

      tx_q = '{8'h00, 8'h04, 8'h10, 8'h01, 8'h20, 8'h02, 8'h30, 8'h03};
      pulse_start();
      send_stream(0, -1, 3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_err", err, 1'b0);
      model[0] = 16'h1001;
      model[1] = 16'h2002;
      model[2] = 16'h3003;
      for (int i = 0; i < 4; i++) rd(i);

`ifdef LOADER_CHECKSUM_EN
      tx_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      pulse_start();
      send_stream(0, -1, 1);
      wait_idle();
      check("csum_bad_err", err, 1'b1);
      check("csum_bad_done", done, 1'b0);
      model[0] = 16'h1234;
      rd(0);
      tx_q = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
      pulse_start();
      send_stream(0, -1, 1);
      wait_idle();
      check("csum_ok_done", done, 1'b1);
      check("csum_ok_err", err, 1'b0);
      model[0] = 16'hABCD;
      rd(0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
